// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/status bundle between the multicycle controller and the MIPS datapath
// master is the controller side, slave is the datapath side.
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic [5:0] func;
  logic       zero;
  logic       overflow;
  logic       PCWr;
  logic       IRWr;
  logic       RegWr;
  logic       ExtOp;
  logic [2:0] ALUctr;
  logic       ALUsrc;
  logic       MemWr;
  logic       RegDst;
  logic       MemtoReg;
  logic       branch;
  logic       jump;

  modport master (
    input  op, func, zero, overflow,
    output PCWr, IRWr, RegWr, ExtOp, ALUctr, ALUsrc, MemWr, RegDst, MemtoReg, branch, jump
  );

  modport slave (
    output op, func, zero, overflow,
    input  PCWr, IRWr, RegWr, ExtOp, ALUctr, ALUsrc, MemWr, RegDst, MemtoReg, branch, jump
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore multicycle control FSM for the MIPS datapath
// Outputs depend only on state and the instruction fields latched in DECODE.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master dp,
  output logic [2:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IFETCH = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEMACC = 3'd3,
    WBACK  = 3'd4,
    HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

  state_t           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       func_q, func_d;
  logic             ov_q, ov_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       pc_wr, ir_wr, reg_wr, mem_wr;
  logic       reg_dst, mem_to_reg, br, jmp, halt_o;
  logic [2:0] alu_ctr;
  logic       alu_src, ext_op;
  logic       legal;

  // Legality is judged on the live IR fields, since op_q/func_q only update at the end of DECODE.
  always_comb begin
    legal = 1'b0;
    case (dp.op)
      OP_R: legal = (dp.func == F_ADD)  || (dp.func == F_ADDU) ||
                    (dp.func == F_SUB)  || (dp.func == F_SUBU) ||
                    (dp.func == F_SLT)  || (dp.func == F_SLTU);
      OP_ORI, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  logic [2:0] dec_alu;
  logic       dec_src, dec_ext;
  always_comb begin
    dec_alu = 3'b000;
    dec_src = 1'b0;
    dec_ext = 1'b0;
    case (op_q)
      OP_R: begin
        case (func_q)
          F_ADD:   dec_alu = 3'b001;
          F_SUBU:  dec_alu = 3'b100;
          F_SUB:   dec_alu = 3'b101;
          F_SLTU:  dec_alu = 3'b110;
          F_SLT:   dec_alu = 3'b111;
          default: dec_alu = 3'b000;
        endcase
      end
      OP_ORI: begin
        dec_alu = 3'b010;
        dec_src = 1'b1;
      end
      OP_ADDIU, OP_LW, OP_SW: begin
        dec_src = 1'b1;
        dec_ext = 1'b1;
      end
      OP_BEQ:  dec_alu = 3'b100;
      default: dec_alu = 3'b000;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    func_d     = func_q;
    ov_d       = ov_q;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    br         = 1'b0;
    jmp        = 1'b0;
    halt_o     = 1'b0;
    alu_ctr    = 3'b000;
    alu_src    = 1'b0;
    ext_op     = 1'b0;
    case (state_q)
      IFETCH: begin
        ir_wr   = 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        op_d    = dp.op;
        func_d  = dp.func;
        state_d = legal ? EXEC : HALT;
      end
      EXEC: begin
        alu_ctr = dec_alu;
        alu_src = dec_src;
        ext_op  = dec_ext;
        ov_d    = dp.overflow;
        if (op_q == OP_BEQ) begin
          pc_wr   = 1'b1;
          br      = 1'b1;
          state_d = IFETCH;
        end else if (op_q == OP_J) begin
          pc_wr   = 1'b1;
          jmp     = 1'b1;
          state_d = IFETCH;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          state_d = MEMACC;
        end else begin
          state_d = WBACK;
        end
      end
      MEMACC: begin
        alu_ctr = dec_alu;
        alu_src = dec_src;
        ext_op  = dec_ext;
        if (op_q == OP_SW) begin
          mem_wr  = 1'b1;
          pc_wr   = 1'b1;
          state_d = IFETCH;
        end else begin
          state_d = WBACK;
        end
      end
      WBACK: begin
        alu_ctr    = dec_alu;
        alu_src    = dec_src;
        ext_op     = dec_ext;
        // A trapping add/sub discards its result but still retires.
        reg_wr     = !((op_q == OP_R) && (func_q == F_ADD || func_q == F_SUB) && ov_q);
        reg_dst    = (op_q == OP_R);
        mem_to_reg = (op_q == OP_LW);
        pc_wr      = 1'b1;
        state_d    = IFETCH;
      end
      HALT: begin
        halt_o  = 1'b1;
        state_d = HALT;
      end
      default: state_d = HALT;
    endcase
    if (rst) begin
      pc_wr  = 1'b0;
      ir_wr  = 1'b0;
      reg_wr = 1'b0;
      mem_wr = 1'b0;
    end
    cnt_d = cnt_q + CNT_W'(pc_wr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IFETCH;
      op_q    <= 6'd0;
      func_q  <= 6'd0;
      ov_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      ov_q    <= ov_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dp.PCWr     = pc_wr;
  assign dp.IRWr     = ir_wr;
  assign dp.RegWr    = reg_wr;
  assign dp.MemWr    = mem_wr;
  assign dp.ExtOp    = ext_op;
  assign dp.ALUctr   = alu_ctr;
  assign dp.ALUsrc   = alu_src;
  assign dp.RegDst   = reg_dst;
  assign dp.MemtoReg = mem_to_reg;
  assign dp.branch   = br;
  assign dp.jump     = jmp;
  assign state       = state_q;
  assign halted      = halt_o;
  assign instr_count = cnt_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Sequential control unit that sits directly upstream of the MIPS datapath and drives all of its control inputs.
- It consumes the datapath's op, func, zero and overflow outputs.
- The datapath moves to a multicycle organisation: PC write and IR write are gated by this FSM instead of advancing every clock.
- Supports addu, subu, add, sub, slt, sltu, ori, addiu, lw, sw, beq and j; any other encoding halts the machine.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
op  in  6  instruction[31:26] from datapath IR
func  in  6  instruction[5:0] from datapath IR
zero  in  1  ALU zero flag from datapath
overflow  in  1  ALU overflow flag from datapath
PCWr  out  1  PC write enable; branch/jump only meaningful while high
IRWr  out  1  instruction register write enable
RegWr  out  1  register file write enable
ExtOp  out  1  1 = sign-extend imm16, 0 = zero-extend
ALUctr  out  3  ALU operation
ALUsrc  out  1  1 = imm32, 0 = busB
MemWr  out  1  data memory write enable
RegDst  out  1  1 = Rd, 0 = Rt
MemtoReg  out  1  1 = memory data, 0 = ALU result
branch  out  1  take branch target when zero=1
jump  out  1  take jump target
state  out  3  current FSM state (debug)
halted  out  1  illegal instruction trap
instr_count  out  CNT_W  retired-instruction counter

Behaviour:
- Clock/reset: one clock, clk; reset rst is synchronous and active-high.
- State encoding: IFETCH=0, DECODE=1, EXEC=2, MEMACC=3, WBACK=4, HALT=7.
- On rst: state=IFETCH, op_q=func_q=0, ov_q=0, instr_count=0, halted=0. All write enables (PCWr, IRWr, RegWr, MemWr) are 0 while rst is high. rst wins over every other event, including mid-instruction and in HALT.
- ALUctr encoding:
  - 000 addu
  - 001 add
  - 010 or
  - 100 subu
  - 101 sub
  - 110 sltu
  - 111 slt
- IFETCH:
  - IRWr=1.
  - Next state: DECODE.
- DECODE:
  - Latch op_q and func_q from op and func.
  - A legal instruction goes to EXEC.
  - An illegal op, or op=000000 with an unlisted func, goes to HALT.
- EXEC: ALUctr, ALUsrc and ExtOp are driven from op_q/func_q.
  - R-type: ALUsrc=0.
  - ori: ALUsrc=1, ExtOp=0, ALUctr=010.
  - addiu, lw, sw: ALUsrc=1, ExtOp=1, ALUctr=000.
  - beq: ALUctr=100, ALUsrc=0, PCWr=1, branch=1; next state IFETCH.
  - j: PCWr=1, jump=1; next state IFETCH.
  - ov_q captures overflow at the end of EXEC.
  - R-type, ori and addiu go to WBACK; lw and sw go to MEMACC.
- MEMACC:
  - ALU controls are held as in EXEC.
  - sw: MemWr=1, PCWr=1; next state IFETCH.
  - lw: next state WBACK.
- WBACK:
  - ALU controls are held.
  - RegWr=1, except for add/sub with ov_q=1, where RegWr=0 (result discarded, PC still advances).
  - RegDst=1 for R-type, 0 otherwise.
  - MemtoReg=1 for lw, 0 otherwise.
  - PCWr=1; next state IFETCH.
- HALT:
  - halted=1; all enables 0.
  - Stays in HALT until rst.
- Outputs: combinational functions of state, op_q and func_q (Moore style). Every output not listed above is 0 for the current state.
- PCWr rules:
  - PCWr is high exactly one cycle per retired instruction.
  - branch and jump are never high together.
  - IRWr and PCWr are never high in the same cycle.
- instr_count increments by 1 in every cycle with PCWr=1 and wraps from 2^CNT_W-1 to 0.
- Cycles per instruction:
  - beq, j: 3
  - sw, R-type, ori, addiu: 4
  - lw: 5

Test Plan:
- Reset, then op=000000 func=100001 (addu) held -> states 0,1,2,4,0. ALUctr=000 in EXEC. In WBACK RegWr=1, RegDst=1, PCWr=1. instr_count=1 after 4 cycles.
- lw (op=100011), then sw (op=101011) ->
  - lw: states 0,1,2,3,4; MemtoReg=1, RegDst=0, RegWr=1 in WBACK.
  - sw: states 0,1,2,3; MemWr=1 and PCWr=1 only in MEMACC; RegWr never 1.
  - instr_count=2.
- beq (op=000100) with zero=1, then j (op=000010) ->
  - beq: 3 cycles each; branch=1 and PCWr=1 in EXEC, ALUctr=100.
  - j: jump=1 and PCWr=1 in EXEC; branch=0.
- add (func=100000) with overflow=1 in EXEC -> WBACK has RegWr=0, PCWr=1, instr_count increments. The same with overflow=0 gives RegWr=1.
- op=111111 -> DECODE goes to HALT (state=7), halted=1, no enable high for 20 cycles. rst pulse returns to IFETCH with halted=0 and instr_count=0.
- Assert rst during MEMACC of sw -> MemWr=0 in that cycle, state=IFETCH the next cycle. Separately, force instr_count to all-ones (CNT_W=4 build: 15) and retire one instruction -> count=0.
